// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch + data load/store) in front of a
// single-port block memory with a one-cycle registered read.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_e;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

  state_e              state_q;
  owner_e              owner_q;
  logic [STREAK_W-1:0] streak_q;

  logic                if_gnt_q;
  logic                if_rvalid_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic                d_gnt_q;
  logic                d_done_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_din_q;

  logic starved;
  logic fetch_wins;
  logic data_wins;
  logic grant_if;
  logic grant_d;

  // Data has priority unless fetch has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    starved    = (streak_q == STREAK_W'(STARVE_LIMIT));
    fetch_wins = if_req && (!d_req || starved);
    data_wins  = d_req && !fetch_wins;
    grant_if   = (state_q == IDLE) && fetch_wins;
    grant_d    = (state_q == IDLE) && data_wins;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      streak_q    <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_gnt_q     <= 1'b0;
      d_done_q    <= 1'b0;
      d_rdata_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_done_q    <= 1'b0;

      if (!if_req || grant_if) begin
        streak_q <= '0;
      end else if (grant_d && !starved) begin
        streak_q <= streak_q + STREAK_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (grant_if) begin
            mem_addr_q <= if_addr;
            mem_we_q   <= 1'b0;
            owner_q    <= OWN_FETCH;
            if_gnt_q   <= 1'b1;
            state_q    <= ACCESS;
          end else if (grant_d) begin
            mem_addr_q <= d_addr;
            mem_we_q   <= d_we;
            mem_din_q  <= d_wdata;
            owner_q    <= OWN_DATA;
            d_gnt_q    <= 1'b1;
            state_q    <= ACCESS;
          end else begin
            mem_we_q   <= 1'b0;
          end
        end
        // mem_we_q is high here only for a store, so it doubles as the op type.
        ACCESS: begin
          mem_we_q <= 1'b0;
          if (owner_q == OWN_DATA && mem_we_q) begin
            d_done_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            state_q  <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (owner_q == OWN_FETCH) begin
            if_rdata_q  <= mem_dout;
            if_rvalid_q <= 1'b1;
          end else begin
            d_rdata_q   <= mem_dout;
            d_done_q    <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_done    = d_done_q;
  assign d_rdata   = d_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the 1K x 16 single-port block memory (wea/addra/dina/douta, one-cycle registered read).
- Arbitrates two requesters onto that single port:
  - the instruction-fetch port (reads only);
  - the data port (load/store).
- Hides the memory's read latency behind a valid pulse per requester, and bounds fetch starvation with a data-streak counter.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words).
- DATA_W, 16, memory word width.
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win.

Ports:
- clk  in  1  system clock; also drives the block memory clka.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted, if_addr captured.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word; holds until the next fetch completes.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_done  out  1  one-cycle pulse: store written, or load data valid on d_rdata.
- d_rdata  out  DATA_W  loaded word; holds until the next load completes.
- mem_we  out  1  to memory wea.
- mem_addr  out  ADDR_W  to memory addra.
- mem_din  out  DATA_W  to memory dina.
- mem_dout  in  DATA_W  from memory douta.

Behaviour:
- All outputs are registered.
- Reset values:
  - all pulses 0;
  - mem_we 0, mem_addr 0, mem_din 0;
  - if_rdata 0, d_rdata 0;
  - streak counter 0;
  - state IDLE.
- FSM states are IDLE, ACCESS and RD_WAIT, plus an owner flag (FETCH/DATA).
- IDLE, at a clock edge with a request present:
  - pick the winner;
  - register mem_addr (and mem_we = d_we and mem_din = d_wdata for data; mem_we = 0 for fetch);
  - pulse the winner's gnt;
  - go to ACCESS.
  - With no request, stay in IDLE with mem_we = 0.
- Winner selection:
  - d_req wins by default.
  - Fetch wins if only if_req is set, or if if_req is set and streak == STARVE_LIMIT.
- Streak counter:
  - increments on a data grant while if_req is high;
  - clears on a fetch grant or when if_req is low;
  - saturates at STARVE_LIMIT.
- ACCESS: the memory samples addr/we at the end of this cycle.
  - Next state: mem_we = 0.
  - Store: pulse d_done, go to IDLE.
  - Load or fetch: go to RD_WAIT.
- RD_WAIT: mem_dout is valid.
  - Capture it into the owner's rdata register.
  - Pulse the owner's rvalid/done.
  - Go to IDLE.
- Latency, counted from the gnt cycle:
  - store d_done 1 cycle later;
  - load or fetch rvalid 2 cycles later.
  - Throughput: one read per 3 cycles, one write per 2 cycles.
- mem_we is high for exactly one cycle (ACCESS) per store and never during a fetch.
- A simultaneous if_req and d_req is resolved by the rules above; the loser keeps waiting with no gnt.
- A request deasserted before gnt is dropped and has no effect.
- Address and data are captured only at grant; later input changes are ignored.
- Reset mid-operation:
  - return to IDLE next cycle;
  - mem_we = 0;
  - no pending rvalid or done is emitted;
  - the rdata registers clear to 0.
- Address wrap follows the ADDR_W truncation of the memory; the block performs no range checking.

Test Plan:
- Reset, then fetch if_addr=0 → if_gnt pulse, mem_addr=0, if_rvalid exactly 2 cycles after if_gnt, if_rdata equals the memory init word 0 (0x0000).
- Store d_addr=5, d_wdata=0xBEEF, then load d_addr=5 → mem_we high exactly 1 cycle, d_done 1 cycle after the store gnt; the load returns d_rdata=0xBEEF 2 cycles after its gnt.
- if_req and d_req (load) raised together → d_gnt first; if_gnt 3 cycles later; each rvalid/done goes only to its owner.
- d_req held continuously with if_req high → exactly 4 data grants, then if_gnt, then data resumes; the streak resets.
- Assert reset during RD_WAIT of a fetch from addr 2 → no if_rvalid, mem_we=0, state IDLE; a following fetch of addr 2 completes normally.
- Change d_addr/d_wdata in the cycle after d_gnt → the memory is written at the originally captured address and data only.
